// File: rtl/wb_msg_sequencer_pkg.sv
// Shared bus widths, FSM encodings and response priority for the NIC
// packet-to-message Wishbone sequencer.
package wb_msg_sequencer_pkg;

    localparam int BUS_ADDRESS_WIDTH = 32;
    localparam int BUS_DATA_WIDTH    = 32;
    localparam int BUS_SEL_WIDTH     = BUS_DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_XFER    = 3'd2,
        ST_DONE    = 3'd3,
        ST_BACKOFF = 3'd4
    } seq_state_t;

    // Slave responses; simultaneous responses resolve ack > err > rty.
    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_ACK  = 2'd1,
        RESP_ERR  = 2'd2,
        RESP_RTY  = 2'd3
    } resp_t;

    function automatic resp_t resolve_resp(input logic ack, input logic err, input logic rty);
        resp_t r;
        r = RESP_NONE;
        if (ack) begin
            r = RESP_ACK;
        end else if (err) begin
            r = RESP_ERR;
        end else if (rty) begin
            r = RESP_RTY;
        end
        return r;
    endfunction

endpackage

// File: rtl/wb_msg_sequencer_retry_backoff.sv
// Retry counter, post-retry backoff timer and no-response watchdog for the
// message sequencer.
module wb_msg_sequencer_retry_backoff #(
    parameter int MAX_RETRIES     = 8,
    parameter int BACKOFF_CYCLES  = 4,
    parameter int WATCHDOG_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic rty,
    input  logic clear,
    input  logic wait_cycle,
    output logic backoff_done,
    output logic retry_exceeded,
    output logic watchdog_expired
);

    localparam int RC_W = $clog2(MAX_RETRIES + 2);
    localparam int BO_W = $clog2(BACKOFF_CYCLES + 1);
    localparam int WD_W = $clog2(WATCHDOG_CYCLES + 1);

    logic [RC_W-1:0] retry_cnt;
    logic [BO_W-1:0] bo_cnt;
    logic            bo_active;
    logic [WD_W-1:0] wd_cnt;

    // Compared before the increment: a retry seen here would be one too many.
    assign retry_exceeded   = (retry_cnt >= RC_W'(MAX_RETRIES));
    assign backoff_done     = bo_active && (bo_cnt == BO_W'(BACKOFF_CYCLES - 1));
    assign watchdog_expired = wait_cycle && (wd_cnt == WD_W'(WATCHDOG_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            retry_cnt <= '0;
        end else if (rty) begin
            retry_cnt <= retry_cnt + RC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            bo_active <= 1'b0;
            bo_cnt    <= '0;
        end else if (start) begin
            bo_active <= 1'b1;
            bo_cnt    <= '0;
        end else if (bo_active) begin
            if (backoff_done) begin
                bo_active <= 1'b0;
            end else begin
                bo_cnt <= bo_cnt + BO_W'(1);
            end
        end
    end

    // Counts only consecutive unanswered XFER cycles; any response restarts it.
    always_ff @(posedge clk) begin
        if (rst || !wait_cycle) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
        end
    end

endmodule

// File: rtl/wb_msg_sequencer.sv
// Wishbone master that carries one queued message per bus tenure, handling
// slave retry with backoff, slave error and a no-response watchdog.
module wb_msg_sequencer
    import wb_msg_sequencer_pkg::*;
#(
    parameter int N_BITS_BURST_LENGHT = 7,
    parameter int ADDR_INCR           = 4,
    parameter int MAX_RETRIES         = 8,
    parameter int BACKOFF_CYCLES      = 4,
    parameter int WATCHDOG_CYCLES     = 255
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           msg_avail_i,
    input  logic [BUS_ADDRESS_WIDTH-1:0]   address_i,
    input  logic [BUS_DATA_WIDTH-1:0]      data_i,
    input  logic [BUS_SEL_WIDTH-1:0]       sel_i,
    input  logic                           we_i,
    input  logic [N_BITS_BURST_LENGHT-1:0] burst_lenght_i,
    output logic                           next_data_o,
    output logic                           retry_o,
    output logic                           message_transmitted_o,
    output logic                           bus_req_o,
    input  logic                           bus_gnt_i,
    output logic                           cyc_o,
    output logic                           stb_o,
    output logic                           we_o,
    output logic [BUS_ADDRESS_WIDTH-1:0]   adr_o,
    output logic [BUS_DATA_WIDTH-1:0]      dat_o,
    output logic [BUS_SEL_WIDTH-1:0]       sel_o,
    input  logic [BUS_DATA_WIDTH-1:0]      dat_i,
    input  logic                           ack_i,
    input  logic                           err_i,
    input  logic                           rty_i,
    output logic [BUS_DATA_WIDTH-1:0]      rd_data_o,
    output logic                           rd_valid_o,
    output logic                           error_o
);

    seq_state_t                     state;
    seq_state_t                     next_state;
    resp_t                          resp;
    logic [N_BITS_BURST_LENGHT-1:0] beat_cnt;
    logic [N_BITS_BURST_LENGHT-1:0] last_beat;
    logic                           in_xfer;
    logic                           msg_done;
    logic                           wait_cycle;
    logic                           beat_inc;
    logic                           drop;
    logic                           rty_accept;
    logic                           bo_start;
    logic                           read_ack;
    logic                           backoff_done;
    logic                           retry_exceeded;
    logic                           watchdog_expired;

    assign in_xfer    = (state == ST_XFER);
    assign msg_done   = (state == ST_DONE);
    assign resp       = resolve_resp(ack_i, err_i, rty_i);
    assign wait_cycle = in_xfer && (resp == RESP_NONE);
    assign read_ack   = in_xfer && (resp == RESP_ACK) && !we_i;

    // A zero length is handled as a single beat, so the beat counter never wraps.
    assign last_beat = (burst_lenght_i == '0) ? '0
                     : burst_lenght_i - N_BITS_BURST_LENGHT'(1);

    assign adr_o = in_xfer ? address_i + BUS_ADDRESS_WIDTH'(beat_cnt) * BUS_ADDRESS_WIDTH'(ADDR_INCR)
                           : '0;
    assign dat_o = in_xfer ? data_i : '0;
    assign sel_o = in_xfer ? sel_i : '0;
    assign we_o  = in_xfer && we_i;

    wb_msg_sequencer_retry_backoff #(
        .MAX_RETRIES     (MAX_RETRIES),
        .BACKOFF_CYCLES  (BACKOFF_CYCLES),
        .WATCHDOG_CYCLES (WATCHDOG_CYCLES)
    ) u_retry_backoff (
        .clk              (clk),
        .rst              (rst),
        .start            (bo_start),
        .rty              (rty_accept),
        .clear            (msg_done),
        .wait_cycle       (wait_cycle),
        .backoff_done     (backoff_done),
        .retry_exceeded   (retry_exceeded),
        .watchdog_expired (watchdog_expired)
    );

    always_comb begin
        next_state            = state;
        next_data_o           = 1'b0;
        retry_o               = 1'b0;
        message_transmitted_o = 1'b0;
        beat_inc              = 1'b0;
        drop                  = 1'b0;
        rty_accept            = 1'b0;
        bo_start              = 1'b0;
        case (state)
            ST_IDLE: begin
                if (msg_avail_i) begin
                    next_state = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus_gnt_i) begin
                    next_state = ST_XFER;
                end
            end
            ST_XFER: begin
                // Grant is deliberately not looked at: the tenure lasts until the message ends.
                case (resp)
                    RESP_ACK: begin
                        if (beat_cnt == last_beat) begin
                            next_state = ST_DONE;
                        end else begin
                            next_data_o = 1'b1;
                            beat_inc    = 1'b1;
                        end
                    end
                    RESP_ERR: begin
                        next_state = ST_DONE;
                        drop       = 1'b1;
                    end
                    RESP_RTY: begin
                        retry_o    = 1'b1;
                        rty_accept = 1'b1;
                        if (retry_exceeded) begin
                            next_state = ST_DONE;
                            drop       = 1'b1;
                        end else begin
                            next_state = ST_BACKOFF;
                            bo_start   = 1'b1;
                        end
                    end
                    default: begin
                        if (watchdog_expired) begin
                            next_state = ST_DONE;
                            drop       = 1'b1;
                        end
                    end
                endcase
            end
            ST_DONE: begin
                message_transmitted_o = 1'b1;
                next_state            = ST_IDLE;
            end
            ST_BACKOFF: begin
                if (backoff_done) begin
                    next_state = ST_REQ;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Bus strobes are registered from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            beat_cnt   <= '0;
            cyc_o      <= 1'b0;
            stb_o      <= 1'b0;
            bus_req_o  <= 1'b0;
            rd_data_o  <= '0;
            rd_valid_o <= 1'b0;
            error_o    <= 1'b0;
        end else begin
            state      <= next_state;
            cyc_o      <= (next_state == ST_XFER);
            stb_o      <= (next_state == ST_XFER);
            bus_req_o  <= (next_state == ST_REQ) || (next_state == ST_XFER);
            rd_valid_o <= read_ack;
            error_o    <= drop;
            if (read_ack) begin
                rd_data_o <= dat_i;
            end
            if ((state == ST_REQ) && bus_gnt_i) begin
                beat_cnt <= '0;
            end else if (beat_inc) begin
                beat_cnt <= beat_cnt + N_BITS_BURST_LENGHT'(1);
            end
        end
    end

endmodule

// File: tb/tb_wb_msg_sequencer.sv
// Directed bench for wb_msg_sequencer: bursts, wait states, retry/backoff,
// retry limit, slave error, watchdog, zero length and mid-burst reset.
module tb_wb_msg_sequencer;
    import wb_msg_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        msg_avail_i;
    logic [31:0] address_i;
    logic [31:0] data_i;
    logic [3:0]  sel_i;
    logic        we_i;
    logic [6:0]  burst_lenght_i;
    logic        next_data_o;
    logic        retry_o;
    logic        message_transmitted_o;
    logic        bus_req_o;
    logic        bus_gnt_i;
    logic        cyc_o;
    logic        stb_o;
    logic        we_o;
    logic [31:0] adr_o;
    logic [31:0] dat_o;
    logic [3:0]  sel_o;
    logic [31:0] dat_i;
    logic        ack_i;
    logic        err_i;
    logic        rty_i;
    logic [31:0] rd_data_o;
    logic        rd_valid_o;
    logic        error_o;

    int          assertCount = 0;
    int          failCount = 0;
    logic [31:0] chunk = 32'd0;
    int          nextDataPulses = 0;
    int          retryPulses = 0;
    int          msgTxPulses = 0;
    int          ndBase;
    int          rtBase;
    int          mtBase;
    int          wdHigh;

    wb_msg_sequencer dut (
        .clk                   (clk),
        .rst                   (rst),
        .msg_avail_i           (msg_avail_i),
        .address_i             (address_i),
        .data_i                (data_i),
        .sel_i                 (sel_i),
        .we_i                  (we_i),
        .burst_lenght_i        (burst_lenght_i),
        .next_data_o           (next_data_o),
        .retry_o               (retry_o),
        .message_transmitted_o (message_transmitted_o),
        .bus_req_o             (bus_req_o),
        .bus_gnt_i             (bus_gnt_i),
        .cyc_o                 (cyc_o),
        .stb_o                 (stb_o),
        .we_o                  (we_o),
        .adr_o                 (adr_o),
        .dat_o                 (dat_o),
        .sel_o                 (sel_o),
        .dat_i                 (dat_i),
        .ack_i                 (ack_i),
        .err_i                 (err_i),
        .rty_i                 (rty_i),
        .rd_data_o             (rd_data_o),
        .rd_valid_o            (rd_valid_o),
        .error_o               (error_o)
    );

    always #5 clk = ~clk;

    // Queue model: chunk pointer advances on next_data, rewinds on retry or pop.
    assign data_i = 32'hA000_0000 + chunk;

    always @(posedge clk) begin
        if (rst || retry_o || message_transmitted_o) begin
            chunk <= 32'd0;
        end else if (next_data_o) begin
            chunk <= chunk + 32'd1;
        end
        if (next_data_o) nextDataPulses <= nextDataPulses + 1;
        if (retry_o) retryPulses <= retryPulses + 1;
        if (message_transmitted_o) msgTxPulses <= msgTxPulses + 1;
    end

    task automatic applyStimulus(input logic avail, input logic [31:0] addr,
                                 input logic [6:0] len, input logic we);
        msg_avail_i    = avail;
        address_i      = addr;
        burst_lenght_i = len;
        we_i           = we;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL timeout: run still active at %0t, required to finish earlier", $time);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst = 1'b1;
        msg_avail_i = 1'b0;
        address_i = 32'd0;
        sel_i = 4'hF;
        we_i = 1'b1;
        burst_lenght_i = 7'd0;
        bus_gnt_i = 1'b1;
        dat_i = 32'd0;
        ack_i = 1'b0;
        err_i = 1'b0;
        rty_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("reset cyc", 32'(cyc_o), 0);
        checkOutput("reset stb", 32'(stb_o), 0);
        checkOutput("reset bus_req", 32'(bus_req_o), 0);
        checkOutput("reset msg_tx", 32'(message_transmitted_o), 0);
        checkOutput("reset error", 32'(error_o), 0);
        checkOutput("reset rd_valid", 32'(rd_valid_o), 0);
        checkOutput("reset adr", adr_o, 0);

        $display("[TB] 4-beat write burst, zero-wait slave, grant dropped mid-burst");
        ndBase = nextDataPulses;
        mtBase = msgTxPulses;
        applyStimulus(1'b1, 32'h100, 7'd4, 1'b1);
        @(negedge clk); #1;
        checkOutput("w4 req bus_req", 32'(bus_req_o), 1);
        checkOutput("w4 req cyc", 32'(cyc_o), 0);
        @(negedge clk); ack_i = 1'b1; #1;
        checkOutput("w4 b0 stb", 32'(stb_o), 1);
        checkOutput("w4 b0 adr", adr_o, 32'h100);
        checkOutput("w4 b0 dat", dat_o, 32'hA000_0000);
        checkOutput("w4 b0 sel", 32'(sel_o), 32'hF);
        checkOutput("w4 b0 we", 32'(we_o), 1);
        checkOutput("w4 b0 next_data", 32'(next_data_o), 1);
        @(negedge clk); #1;
        checkOutput("w4 b1 adr", adr_o, 32'h104);
        checkOutput("w4 b1 dat", dat_o, 32'hA000_0001);
        @(negedge clk); bus_gnt_i = 1'b0; #1;
        checkOutput("w4 b2 adr", adr_o, 32'h108);
        checkOutput("w4 b2 dat", dat_o, 32'hA000_0002);
        @(negedge clk); #1;
        checkOutput("w4 b3 adr", adr_o, 32'h10C);
        checkOutput("w4 b3 dat", dat_o, 32'hA000_0003);
        checkOutput("w4 b3 cyc after grant loss", 32'(cyc_o), 1);
        checkOutput("w4 b3 next_data", 32'(next_data_o), 0);
        @(negedge clk); ack_i = 1'b0; msg_avail_i = 1'b0; bus_gnt_i = 1'b1; #1;
        checkOutput("w4 done msg_tx", 32'(message_transmitted_o), 1);
        checkOutput("w4 done cyc", 32'(cyc_o), 0);
        checkOutput("w4 done error", 32'(error_o), 0);
        @(negedge clk); #1;
        checkOutput("w4 idle msg_tx", 32'(message_transmitted_o), 0);
        checkOutput("w4 next_data pulses", nextDataPulses - ndBase, 3);
        checkOutput("w4 msg_tx pulses", msgTxPulses - mtBase, 1);

        $display("[TB] single read with two wait states");
        applyStimulus(1'b1, 32'h200, 7'd1, 1'b0);
        dat_i = 32'hDEADBEEF;
        @(negedge clk); #1;
        @(negedge clk); #1;
        checkOutput("rd w1 stb", 32'(stb_o), 1);
        checkOutput("rd w1 we", 32'(we_o), 0);
        checkOutput("rd w1 adr", adr_o, 32'h200);
        @(negedge clk); #1;
        checkOutput("rd w2 cyc", 32'(cyc_o), 1);
        checkOutput("rd w2 msg_tx", 32'(message_transmitted_o), 0);
        @(negedge clk); ack_i = 1'b1; #1;
        checkOutput("rd ack next_data", 32'(next_data_o), 0);
        checkOutput("rd ack rd_valid", 32'(rd_valid_o), 0);
        @(negedge clk); ack_i = 1'b0; msg_avail_i = 1'b0; dat_i = 32'd0; #1;
        checkOutput("rd rd_valid", 32'(rd_valid_o), 1);
        checkOutput("rd rd_data", rd_data_o, 32'hDEADBEEF);
        checkOutput("rd msg_tx", 32'(message_transmitted_o), 1);
        @(negedge clk); #1;
        checkOutput("rd rd_valid drop", 32'(rd_valid_o), 0);

        $display("[TB] retry on beat 2 then success");
        rtBase = retryPulses;
        applyStimulus(1'b1, 32'h100, 7'd4, 1'b1);
        @(negedge clk); #1;
        @(negedge clk); ack_i = 1'b1; #1;
        checkOutput("rt b0 adr", adr_o, 32'h100);
        @(negedge clk); #1;
        checkOutput("rt b1 adr", adr_o, 32'h104);
        @(negedge clk); ack_i = 1'b0; rty_i = 1'b1; #1;
        checkOutput("rt b2 adr", adr_o, 32'h108);
        checkOutput("rt b2 retry", 32'(retry_o), 1);
        checkOutput("rt b2 next_data", 32'(next_data_o), 0);
        @(negedge clk); rty_i = 1'b0; #1;
        checkOutput("rt bo1 cyc", 32'(cyc_o), 0);
        checkOutput("rt bo1 retry", 32'(retry_o), 0);
        checkOutput("rt bo1 bus_req", 32'(bus_req_o), 0);
        for (int i = 2; i <= 4; i++) begin
            @(negedge clk); #1;
            checkOutput("rt backoff bus_req", 32'(bus_req_o), 0);
        end
        @(negedge clk); #1;
        checkOutput("rt req bus_req", 32'(bus_req_o), 1);
        checkOutput("rt req cyc", 32'(cyc_o), 0);
        @(negedge clk); ack_i = 1'b1; #1;
        checkOutput("rt restart adr", adr_o, 32'h100);
        checkOutput("rt restart dat", dat_o, 32'hA000_0000);
        @(negedge clk); #1;
        checkOutput("rt r1 adr", adr_o, 32'h104);
        @(negedge clk); #1;
        checkOutput("rt r2 adr", adr_o, 32'h108);
        @(negedge clk); #1;
        checkOutput("rt r3 adr", adr_o, 32'h10C);
        @(negedge clk); ack_i = 1'b0; msg_avail_i = 1'b0; #1;
        checkOutput("rt done msg_tx", 32'(message_transmitted_o), 1);
        checkOutput("rt done error", 32'(error_o), 0);
        @(negedge clk); #1;
        checkOutput("rt retry pulses", retryPulses - rtBase, 1);

        $display("[TB] retry limit");
        rtBase = retryPulses;
        applyStimulus(1'b1, 32'h300, 7'd1, 1'b1);
        @(negedge clk); #1;
        for (int a = 1; a <= 9; a++) begin
            @(negedge clk); rty_i = 1'b1; #1;
            checkOutput("lim retry", 32'(retry_o), 1);
            if (a < 9) begin
                @(negedge clk); rty_i = 1'b0; #1;
                checkOutput("lim backoff cyc", 32'(cyc_o), 0);
                repeat (3) @(negedge clk);
                @(negedge clk); #1;
                checkOutput("lim req bus_req", 32'(bus_req_o), 1);
            end
        end
        @(negedge clk); rty_i = 1'b0; msg_avail_i = 1'b0; #1;
        checkOutput("lim msg_tx", 32'(message_transmitted_o), 1);
        checkOutput("lim error", 32'(error_o), 1);
        @(negedge clk); #1;
        checkOutput("lim error clear", 32'(error_o), 0);
        checkOutput("lim retry pulses", retryPulses - rtBase, 9);

        $display("[TB] slave error on beat 0");
        applyStimulus(1'b1, 32'h400, 7'd2, 1'b1);
        @(negedge clk); #1;
        @(negedge clk); err_i = 1'b1; #1;
        checkOutput("err next_data", 32'(next_data_o), 0);
        checkOutput("err retry", 32'(retry_o), 0);
        @(negedge clk); err_i = 1'b0; msg_avail_i = 1'b0; #1;
        checkOutput("err msg_tx", 32'(message_transmitted_o), 1);
        checkOutput("err error", 32'(error_o), 1);
        @(negedge clk); #1;
        checkOutput("err error clear", 32'(error_o), 0);

        $display("[TB] watchdog on silent slave");
        applyStimulus(1'b1, 32'h500, 7'd1, 1'b1);
        @(negedge clk); #1;
        wdHigh = 0;
        for (int i = 0; i < 255; i++) begin
            @(negedge clk); #1;
            if (cyc_o) wdHigh++;
        end
        @(negedge clk); msg_avail_i = 1'b0; #1;
        checkOutput("wd msg_tx", 32'(message_transmitted_o), 1);
        checkOutput("wd error", 32'(error_o), 1);
        checkOutput("wd cyc cycles", wdHigh, 255);

        $display("[TB] zero burst length treated as one beat");
        @(negedge clk);
        applyStimulus(1'b1, 32'h600, 7'd0, 1'b1);
        @(negedge clk); #1;
        @(negedge clk); ack_i = 1'b1; #1;
        checkOutput("len0 adr", adr_o, 32'h600);
        checkOutput("len0 next_data", 32'(next_data_o), 0);
        @(negedge clk); ack_i = 1'b0; #1;
        checkOutput("len0 msg_tx", 32'(message_transmitted_o), 1);
        @(negedge clk); msg_avail_i = 1'b0; #1;
        checkOutput("len0 idle gap bus_req", 32'(bus_req_o), 0);

        $display("[TB] reset mid-burst");
        mtBase = msgTxPulses;
        applyStimulus(1'b1, 32'h100, 7'd4, 1'b1);
        @(negedge clk); #1;
        @(negedge clk); ack_i = 1'b1; #1;
        @(negedge clk); ack_i = 1'b0; rst = 1'b1; #1;
        checkOutput("rst b1 adr", adr_o, 32'h104);
        @(negedge clk); rst = 1'b0; msg_avail_i = 1'b0; #1;
        checkOutput("rst cyc", 32'(cyc_o), 0);
        checkOutput("rst stb", 32'(stb_o), 0);
        checkOutput("rst bus_req", 32'(bus_req_o), 0);
        checkOutput("rst adr", adr_o, 0);
        checkOutput("rst msg_tx", 32'(message_transmitted_o), 0);
        @(negedge clk); #1;
        checkOutput("rst no pop", msgTxPulses - mtBase, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
